emu_stim_sequencer: RTL

- Command-driven controller that sequences the board-level I/O vector of the emulated design: 14-bit input state (SW[9:0], KEY[3:0] at bits 13:10) and 52-bit output state (LED, HEX0..HEX5).
- A host-side script issues SET/WAIT/SAMPLE/WATCH commands over a valid/ready channel. The block drives the input vector, times delays in clock cycles and returns timestamped output snapshots over a second valid/ready channel.
- Sits between the stimulus source and the device-under-test wrapper. It replaces ad-hoc procedural poking of the input vector.

---
 rtl/emu_seq_pkg.sv | 46 ++++
 rtl/emu_stim_sequencer_if.sv | 30 +++
 rtl/emu_seq_timer.sv | 40 ++++
 rtl/emu_stim_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/emu_seq_pkg.sv
// Shared types and constants for the stimulus sequencer.
// Holds the command/state encodings and the board I/O field map.
// No logic; imported by the interface, the top and the bench.
package emu_seq_pkg;

    // Vector widths of the emulated board I/O.
    localparam int IN_W  = 14;
    localparam int OUT_W = 52;
    localparam int CNT_W = 16;
    localparam int ARG_W = (IN_W > CNT_W) ? IN_W : CNT_W;

    // Input vector fields: switches low, push-buttons (active-low) above.
    localparam int SW_LSB  = 0;
    localparam int SW_W    = 10;
    localparam int KEY_LSB = 10;
    localparam int KEY_W   = 4;

    // Output vector fields: LEDs low, then six 7-segment digits.
    localparam int LED_LSB  = 0;
    localparam int LED_W    = 10;
    localparam int HEX_W    = 7;
    localparam int HEX0_LSB = 10;
    localparam int HEX1_LSB = 17;
    localparam int HEX2_LSB = 24;
    localparam int HEX3_LSB = 31;
    localparam int HEX4_LSB = 38;
    localparam int HEX5_LSB = 45;

    // Host command opcodes.
    typedef enum logic [1:0] {
        OP_SET    = 2'd0,
        OP_WAIT   = 2'd1,
        OP_SAMPLE = 2'd2,
        OP_WATCH  = 2'd3
    } op_e;

    // Sequencer control states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WATCH  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/emu_stim_sequencer_if.sv
// Command and response channels between the host script and the sequencer.
// Pure wiring, no latency.
// Both channels are valid/ready; the slave owns cmd_ready and rsp_valid.
interface emu_stim_sequencer_if;
    import emu_seq_pkg::*;

    // Command channel (host -> sequencer)
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [ARG_W-1:0] cmd_arg;

    // Response channel (sequencer -> host)
    logic             rsp_valid;
    logic             rsp_ready;
    logic [OUT_W-1:0] rsp_data;
    logic             rsp_timeout;
    logic [31:0]      rsp_cycle;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_timeout, rsp_cycle
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_timeout, rsp_cycle
    );

endinterface

// File: rtl/emu_seq_timer.sv
// Down-counter shared by WAIT, SETTLE and WATCH; flags the last counted cycle.
// Load takes effect at the next edge; expire_o is combinational from the count.
// No backpressure: load has priority over enable.
module emu_seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload wins over decrement, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of one means the current cycle is the final one of the interval.
    assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/emu_stim_sequencer.sv
// Command-driven sequencer driving the emulated board inputs and snapshotting its outputs.
// SET applies at the accept edge; SAMPLE answers after SETTLE cycles; WATCH on change or expiry.
// One command in flight: cmd_ready only in IDLE; response held until rsp_ready.
module emu_stim_sequencer
    import emu_seq_pkg::*;
#(
    parameter int unsigned     SETTLE     = 1,
    parameter logic [IN_W-1:0] RST_INPUTS = 14'h3C00
) (
    input  logic                 CLK,
    input  logic                 RST,
    emu_stim_sequencer_if.slave  bus,
    output logic [IN_W-1:0]      dut_inputs,
    input  logic [OUT_W-1:0]     dut_outputs,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

    state_e state_q;
    state_e state_d;

    logic [IN_W-1:0]  inputs_q;
    logic [OUT_W-1:0] baseline_q;
    logic [OUT_W-1:0] rsp_data_q;
    logic [31:0]      rsp_cycle_q;
    logic             rsp_timeout_q;
    logic [31:0]      cyc_cnt_q;

    op_e              cmd_op;
    logic [CNT_W-1:0] arg_cnt;
    logic [IN_W-1:0]  arg_inputs;
    logic             accept;
    logic             outputs_changed;

    logic             capture;
    logic             cap_timeout;
    logic             set_ld;
    logic             base_ld;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_expire;

    assign cmd_op          = op_e'(bus.cmd_op);
    assign arg_cnt         = bus.cmd_arg[CNT_W-1:0];
    assign arg_inputs      = bus.cmd_arg[IN_W-1:0];
    assign bus.cmd_ready   = (state_q == ST_IDLE) && !RST;
    assign accept          = bus.cmd_valid && bus.cmd_ready;
    assign outputs_changed = (dut_outputs != baseline_q);

    emu_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .expire_o   (tmr_expire)
    );

    // Next state plus the strobes steering the datapath and the shared timer.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        cap_timeout = 1'b0;
        set_ld      = 1'b0;
        base_ld     = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_SET: begin
                            set_ld = 1'b1;
                        end
                        OP_WAIT: begin
                            // A zero-length wait never leaves IDLE.
                            if (arg_cnt != '0) begin
                                tmr_load = 1'b1;
                                tmr_val  = arg_cnt;
                                state_d  = ST_WAIT;
                            end
                        end
                        OP_SAMPLE: begin
                            if (SETTLE == 0) begin
                                capture = 1'b1;
                                state_d = ST_RESP;
                            end else begin
                                tmr_load = 1'b1;
                                tmr_val  = SETTLE_CNT;
                                state_d  = ST_SETTLE;
                            end
                        end
                        OP_WATCH: begin
                            base_ld = 1'b1;
                            // A zero-length watch expires immediately.
                            if (arg_cnt == '0) begin
                                capture     = 1'b1;
                                cap_timeout = 1'b1;
                                state_d     = ST_RESP;
                            end else begin
                                tmr_load = 1'b1;
                                tmr_val  = arg_cnt;
                                state_d  = ST_WATCH;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT: begin
                if (tmr_expire) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_expire) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WATCH: begin
                // An output change beats expiry in the same cycle.
                if (outputs_changed) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else if (tmr_expire) begin
                    capture     = 1'b1;
                    cap_timeout = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any command or pending response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Input drive, WATCH baseline and response snapshot registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inputs_q      <= RST_INPUTS;
            baseline_q    <= '0;
            rsp_data_q    <= '0;
            rsp_cycle_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (set_ld) begin
                inputs_q <= arg_inputs;
            end
            if (base_ld) begin
                baseline_q <= dut_outputs;
            end
            if (capture) begin
                rsp_data_q    <= dut_outputs;
                rsp_cycle_q   <= cyc_cnt_q;
                rsp_timeout_q <= cap_timeout;
            end
        end
    end

    // Free-running timestamp, wraps naturally at 32 bits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
        end
    end

    assign dut_inputs      = inputs_q;
    assign busy            = (state_q != ST_IDLE);
    assign bus.rsp_valid   = (state_q == ST_RESP);
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_cycle   = rsp_cycle_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule
